// File: rtl/div_issue_ctrl.sv
// Divider issue control: latches a DIV/DIVU from EX, handshakes the divider, and writes HI/LO back for one cycle.
// Latency: start rises 1 cycle after the request; write-back comes 1 cycle after ready. DIV_TIMEOUT_EN adds a BUSY watchdog.
// Backpressure: stallreq_o holds the pipeline from request until the result cycle; flush_i annuls an in-flight divide.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_signed_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_signed;
    logic        r_start;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_whilo;
    logic        r_timeout;

    logic        w_issue;
    logic        w_tmo;

    assign w_issue = (r_state == IDLE) && div_req_i && !flush_i;

`ifdef DIV_TIMEOUT_EN
    logic [5:0] r_cnt;

    // Counts BUSY cycles; reads 0 in the first BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 6'd0;
        end else if (w_issue) begin
            r_cnt <= 6'd0;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign w_tmo = (r_state == BUSY) && (r_cnt == 6'(TIMEOUT_CYCLES - 1))
                   && !div_ready_i && !flush_i;
`else
    // Watchdog compiled out; the limit has no effect in this build.
    assign w_tmo = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_signed  <= 1'b0;
            r_start   <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_whilo   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_op1    <= reg1_i;
                        r_op2    <= reg2_i;
                        r_signed <= div_signed_i;
                        r_start  <= 1'b1;
                        r_state  <= BUSY;
                    end else begin
                        r_start  <= 1'b0;
                    end
                end
                BUSY: begin
                    // Flush wins over a simultaneous ready: the instruction is dead.
                    if (flush_i) begin
                        r_start <= 1'b0;
                        r_state <= IDLE;
                    end else if (div_ready_i) begin
                        r_hi    <= div_result_i[63:32];
                        r_lo    <= div_result_i[31:0];
                        r_whilo <= 1'b1;
                        r_start <= 1'b0;
                        r_state <= DONE;
                    end else if (w_tmo) begin
                        r_hi      <= 32'd0;
                        r_lo      <= 32'd0;
                        r_whilo   <= 1'b0;
                        r_start   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_whilo <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_start <= 1'b0;
                    r_whilo <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stallreq_o    = w_issue || (r_state == BUSY);
    assign div_annul_o   = (r_state == BUSY) && (flush_i || w_tmo);
    assign whilo_o       = (r_state == DONE) && r_whilo && !flush_i;
    assign div_opdata1_o = r_op1;
    assign div_opdata2_o = r_op2;
    assign div_signed_o  = r_signed;
    assign div_start_o   = r_start;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign div_timeout_o = r_timeout;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, scoreboard of expected HI/LO write-backs.
module tb_div_issue_ctrl;

`ifdef DIV_TIMEOUT_EN
    localparam int TMO       = 8;
    localparam int LAT       = 5;
    localparam int FLUSH_CYC = 3;
`else
    localparam int TMO       = 40;
    localparam int LAT       = 33;
    localparam int FLUSH_CYC = 10;
`endif

    logic        clk;
    logic        rst;
    logic        div_req_i;
    logic        div_signed_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic        div_signed_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_timeout_o;

    div_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_req_i     (div_req_i),
        .div_signed_i  (div_signed_i),
        .reg1_i        (reg1_i),
        .reg2_i        (reg2_i),
        .flush_i       (flush_i),
        .div_result_i  (div_result_i),
        .div_ready_i   (div_ready_i),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .div_signed_o  (div_signed_o),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .stallreq_o    (stallreq_o),
        .whilo_o       (whilo_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_timeout_o (div_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_wb     = 0;
    bit never_ready = 1'b0;
    int m_cnt    = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: ready LAT cycles after start, held until start drops.
    always @(negedge clk) begin
        if (!div_start_o) begin
            m_cnt       = 0;
            div_ready_i = 1'b0;
        end else if (!div_ready_i) begin
            m_cnt++;
            if (m_cnt >= LAT && !never_ready) begin
                div_ready_i  = 1'b1;
                div_result_i = div_ref(div_opdata1_o, div_opdata2_o, div_signed_o);
            end
        end
    end

    // Write-back monitor: every whilo pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst && whilo_o) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", whilo_o, 1'b0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wb_hi", hi_o, e[63:32]);
                check("wb_lo", lo_o, e[31:0]);
                n_wb++;
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        @(posedge clk); #1;
        div_req_i = 1'b1; reg1_i = a; reg2_i = b; div_signed_i = s;
        @(negedge clk);
        check({tag, "_stall_req"}, stallreq_o, 1'b1);
        check({tag, "_start_c0"}, div_start_o, 1'b0);
        @(posedge clk); #1;
        reg1_i = ~a; reg2_i = ~b; div_signed_i = ~s;
        @(negedge clk);
        check({tag, "_start_c1"}, div_start_o, 1'b1);
        check({tag, "_op1"}, div_opdata1_o, a);
        check({tag, "_op2"}, div_opdata2_o, b);
        check({tag, "_signed"}, div_signed_o, s);
        check({tag, "_annul_busy"}, div_annul_o, 1'b0);
        check({tag, "_stall_busy1"}, stallreq_o, 1'b1);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        exp_q.push_back({ehi, elo});
        start_req(a, b, s, tag);
        while (!whilo_o && n < 300) begin
            if (!stallreq_o) bad++;
            n++;
            @(negedge clk);
        end
        check({tag, "_wb_seen"}, whilo_o, 1'b1);
        check({tag, "_stall_drop"}, bad, 0);
        check({tag, "_done_stall"}, stallreq_o, 1'b0);
        check({tag, "_done_start"}, div_start_o, 1'b0);
        check({tag, "_done_tmo"}, div_timeout_o, 1'b0);
    endtask

    task automatic idle_chk(input string tag);
        @(posedge clk); #1;
        div_req_i = 1'b0;
        @(negedge clk);
        check({tag, "_idle_whilo"}, whilo_o, 1'b0);
        check({tag, "_idle_start"}, div_start_o, 1'b0);
        check({tag, "_idle_stall"}, stallreq_o, 1'b0);
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_start"}, div_start_o, 1'b0);
        check({tag, "_op1"}, div_opdata1_o, 32'd0);
        check({tag, "_op2"}, div_opdata2_o, 32'd0);
        check({tag, "_signed"}, div_signed_o, 1'b0);
        check({tag, "_hi"}, hi_o, 32'd0);
        check({tag, "_lo"}, lo_o, 32'd0);
        check({tag, "_whilo"}, whilo_o, 1'b0);
        check({tag, "_stall"}, stallreq_o, 1'b0);
        check({tag, "_annul"}, div_annul_o, 1'b0);
        check({tag, "_tmo"}, div_timeout_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1, "bench timeout");
    end

    initial begin
        int wb_before;
        rst = 1'b0;
        div_req_i = 1'b0; div_signed_i = 1'b0; reg1_i = 32'd0; reg2_i = 32'd0;
        flush_i = 1'b0; div_result_i = 64'd0; div_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst = 1'b1;

        // 1: DIVU 100/7
        do_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, "t1");
        idle_chk("t1");

        // 2: DIV -7/2
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "t2");
        idle_chk("t2");

        // 3: flush in BUSY
        wb_before = n_wb;
        start_req(32'd50, 32'd5, 1'b0, "t3");
        repeat (FLUSH_CYC - 1) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("t3_annul", div_annul_o, 1'b1);
        check("t3_stall", stallreq_o, 1'b1);
        @(posedge clk); #1;
        flush_i = 1'b0; div_req_i = 1'b0;
        @(negedge clk);
        check("t3_start_off", div_start_o, 1'b0);
        check("t3_annul_off", div_annul_o, 1'b0);
        check("t3_stall_off", stallreq_o, 1'b0);
        repeat (LAT + 3) @(negedge clk);
        check("t3_no_wb", n_wb, wb_before);

        // 4: back-to-back DIVU 20/3 then 9/4
        do_div(32'd20, 32'd3, 1'b0, 32'd2, 32'd6, "t4a");
        do_div(32'd9, 32'd4, 1'b0, 32'd1, 32'd2, "t4b");
        idle_chk("t4");

        // 5: async reset mid-BUSY
        start_req(32'd1000, 32'd10, 1'b0, "t5");
        repeat (5) @(posedge clk);
        #1 div_req_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        all_zero("t5_rst");
        @(negedge clk);
        rst = 1'b1;
        do_div(32'd1000, 32'd10, 1'b0, 32'd0, 32'd100, "t5b");
        idle_chk("t5b");

`ifdef DIV_TIMEOUT_EN
        // 6: watchdog with a divider that never answers
        never_ready = 1'b1;
        wb_before = n_wb;
        start_req(32'd5, 32'd1, 1'b0, "t6");
        for (int k = 2; k <= TMO; k++) begin
            @(negedge clk);
            if (k < TMO) begin
                check("t6_annul_early", div_annul_o, 1'b0);
            end else begin
                check("t6_annul", div_annul_o, 1'b1);
                check("t6_tmo_pre", div_timeout_o, 1'b0);
            end
        end
        @(negedge clk);
        check("t6_tmo", div_timeout_o, 1'b1);
        check("t6_whilo", whilo_o, 1'b0);
        check("t6_hi", hi_o, 32'd0);
        check("t6_lo", lo_o, 32'd0);
        check("t6_stall", stallreq_o, 1'b0);
        @(posedge clk); #1;
        div_req_i = 1'b0;
        never_ready = 1'b0;
        @(negedge clk);
        check("t6_tmo_off", div_timeout_o, 1'b0);
        check("t6_start", div_start_o, 1'b0);
        check("t6_no_wb", n_wb, wb_before);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
